// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive controller
package uart_pkg;

  // Receiver handshake phases: waiting for a byte, acking it, waiting for ready to drop
  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_ACK  = 2'd1,
    A_WAIT = 2'd2
  } ack_state_e;

  // Quiet bit-times that make up one full frame; below this the line may be mid-frame
  localparam int unsigned QUIET_FRAME_BITS = 12;

  // Shortest bit-time the quiet timer will measure, in clock cycles
  localparam int unsigned DIVIDER_FLOOR = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - power-of-two receive FIFO with registered head output
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = data_q;

  // Next pointers, occupancy and the head value that will be visible after this edge
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    data_d   = data_q;
    if (count_d != '0) begin
      // The new head is the byte being written right now when the FIFO drains to it
      if (do_push && (rd_ptr_d == wr_ptr_q)) begin
        data_d = wdata_i;
      end else begin
        data_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and registered head
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver controller: config owner, byte drain, idle timeout
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16,
  parameter int unsigned DEFAULT_DIVIDER     = 87,
  parameter int unsigned FIFO_DEPTH          = 16,
  parameter int unsigned IDLE_BITS           = 32
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic                           rx_serial_i,
  input  logic [7:0]                     rx_data_i,
  input  logic                           rx_ready_i,
  output logic                           rx_ack_o,
  output logic [CLOCK_DIVIDER_WIDTH-1:0] rx_clock_divider_o,
  output logic                           rx_parity_bit_o,
  output logic                           rx_parity_even_o,
  input  logic                           cfg_we_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] cfg_divider_i,
  input  logic                           cfg_parity_bit_i,
  input  logic                           cfg_parity_even_i,
  output logic                           cfg_pending_o,
  input  logic                           pop_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  output logic [$clog2(FIFO_DEPTH):0]    count_o,
  output logic                           overflow_o,
  input  logic                           overflow_clr_i,
  output logic                           timeout_o
);

  localparam int unsigned DW = CLOCK_DIVIDER_WIDTH;
  localparam int unsigned QW = $clog2(IDLE_BITS + 1);
  localparam logic [DW-1:0] DIV_RESET   = DW'(DEFAULT_DIVIDER);
  localparam logic [DW-1:0] DIV_FLOOR   = DW'(DIVIDER_FLOOR);
  localparam logic [QW-1:0] QUIET_MAX   = QW'(IDLE_BITS);
  localparam logic [QW-1:0] QUIET_FRAME = QW'(QUIET_FRAME_BITS);

  ack_state_e    state_q;
  logic          ack_q;

  logic [DW-1:0] div_q;
  logic          par_bit_q;
  logic          par_even_q;
  logic          pend_q;
  logic [DW-1:0] pend_div_q;
  logic          pend_bit_q;
  logic          pend_even_q;

  logic [DW-1:0] timer_q, timer_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          burst_q;
  logic          timeout_q;
  logic          overflow_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push_attempt;
  logic          drop;
  logic          fifo_push;
  logic          line_quiet;
  logic          apply;
  logic [DW-1:0] bit_len;
  logic          bit_last;
  logic          fire;

  assign push_attempt = (state_q == A_IDLE) && rx_ready_i;
  assign drop         = push_attempt && fifo_full && !pop_i;
  assign fifo_push    = push_attempt && !drop;
  assign line_quiet   = (quiet_q >= QUIET_FRAME);
  assign apply        = pend_q && line_quiet && (state_q == A_IDLE);
  assign bit_len      = (div_q < DIV_FLOOR) ? DIV_FLOOR : div_q;
  assign bit_last     = (timer_q >= bit_len - DW'(1));

  assign rx_ack_o           = ack_q;
  assign rx_clock_divider_o = div_q;
  assign rx_parity_bit_o    = par_bit_q;
  assign rx_parity_even_o   = par_even_q;
  assign cfg_pending_o      = pend_q;
  assign valid_o            = ~fifo_empty;
  assign overflow_o         = overflow_q;
  assign timeout_o          = timeout_q;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push_i    (fifo_push),
    .wdata_i   (rx_data_i),
    .pop_i     (pop_i),
    .rdata_o   (data_o),
    .count_o   (count_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Receiver handshake: one-cycle ack per frame, then wait for ready to fall
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= A_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        A_IDLE: begin
          if (rx_ready_i) begin
            ack_q   <= 1'b1;
            state_q <= A_ACK;
          end
        end
        A_ACK: begin
          ack_q   <= 1'b0;
          state_q <= A_WAIT;
        end
        A_WAIT: begin
          if (!rx_ready_i) begin
            state_q <= A_IDLE;
          end
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= A_IDLE;
        end
      endcase
    end
  end

  // Pending configuration capture and deferred apply once the line is quiet
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_q       <= DIV_RESET;
      par_bit_q   <= 1'b0;
      par_even_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_div_q  <= DIV_RESET;
      pend_bit_q  <= 1'b0;
      pend_even_q <= 1'b0;
    end else begin
      if (apply) begin
        div_q      <= pend_div_q;
        par_bit_q  <= pend_bit_q;
        par_even_q <= pend_even_q;
      end
      if (cfg_we_i) begin
        pend_div_q  <= cfg_divider_i;
        pend_bit_q  <= cfg_parity_bit_i;
        pend_even_q <= cfg_parity_even_i;
        pend_q      <= 1'b1;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

  // Bit timer and saturating quiet-bit counter; any low sample restarts both
  always_comb begin
    timer_d = timer_q;
    quiet_d = quiet_q;
    if (!rx_serial_i) begin
      timer_d = '0;
      quiet_d = '0;
    end else if (apply) begin
      timer_d = '0;
    end else if (bit_last) begin
      timer_d = '0;
      if (quiet_q != QUIET_MAX) begin
        quiet_d = quiet_q + QW'(1);
      end
    end else begin
      timer_d = timer_q + DW'(1);
    end
    fire = burst_q && (quiet_q != QUIET_MAX) && (quiet_d == QUIET_MAX);
  end

  // Quiet timer state; out of reset the line counts as long idle
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      timer_q <= '0;
      quiet_q <= QUIET_MAX;
    end else begin
      timer_q <= timer_d;
      quiet_q <= quiet_d;
    end
  end

  // Burst tracking, one-shot timeout pulse and sticky overflow flag
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      burst_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      burst_q   <= push_attempt | (burst_q & ~fire);
      timeout_q <= fire;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - randomized self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

  localparam int DIVW    = 16;
  localparam int DEF_DIV = 87;
  localparam int DEPTH   = 16;
  localparam int IDLE    = 32;

  logic            clock_i = 1'b0;
  logic            reset_n_i;
  logic            rx_serial_i;
  logic [7:0]      rx_data_i;
  logic            rx_ready_i;
  logic            rx_ack_o;
  logic [DIVW-1:0] rx_clock_divider_o;
  logic            rx_parity_bit_o;
  logic            rx_parity_even_o;
  logic            cfg_we_i;
  logic [DIVW-1:0] cfg_divider_i;
  logic            cfg_parity_bit_i;
  logic            cfg_parity_even_i;
  logic            cfg_pending_o;
  logic            pop_i;
  logic [7:0]      data_o;
  logic            valid_o;
  logic [4:0]      count_o;
  logic            overflow_o;
  logic            overflow_clr_i;
  logic            timeout_o;

  always #5 clock_i = ~clock_i;

  uart_rx_ctrl #(
    .CLOCK_DIVIDER_WIDTH (DIVW),
    .DEFAULT_DIVIDER     (DEF_DIV),
    .FIFO_DEPTH          (DEPTH),
    .IDLE_BITS           (IDLE)
  ) dut (
    .clock_i            (clock_i),
    .reset_n_i          (reset_n_i),
    .rx_serial_i        (rx_serial_i),
    .rx_data_i          (rx_data_i),
    .rx_ready_i         (rx_ready_i),
    .rx_ack_o           (rx_ack_o),
    .rx_clock_divider_o (rx_clock_divider_o),
    .rx_parity_bit_o    (rx_parity_bit_o),
    .rx_parity_even_o   (rx_parity_even_o),
    .cfg_we_i           (cfg_we_i),
    .cfg_divider_i      (cfg_divider_i),
    .cfg_parity_bit_i   (cfg_parity_bit_i),
    .cfg_parity_even_i  (cfg_parity_even_i),
    .cfg_pending_o      (cfg_pending_o),
    .pop_i              (pop_i),
    .data_o             (data_o),
    .valid_o            (valid_o),
    .count_o            (count_o),
    .overflow_o         (overflow_o),
    .overflow_clr_i     (overflow_clr_i),
    .timeout_o          (timeout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int to_seen  = 0;

  // Reference model state
  logic [7:0] m_q[$];
  logic [7:0] m_data;
  bit         m_ovf, m_ack, m_taken, m_pend, m_burst, m_to;
  int         m_div, p_div;
  bit         m_pb, m_pe, p_pb, p_pe;
  int         m_base, m_hi;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int quiet_now();
    int len;
    int v;
    len = (m_div < 2) ? 2 : m_div;
    v = m_base + m_hi / len;
    return (v > IDLE) ? IDLE : v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_data = 8'h00; m_ovf = 0; m_ack = 0; m_taken = 0; m_pend = 0;
    m_burst = 0; m_to = 0; m_div = DEF_DIV; p_div = DEF_DIV;
    m_pb = 0; m_pe = 0; p_pb = 0; p_pe = 0;
    m_base = IDLE; m_hi = 0;
  endtask

  task automatic model_edge();
    int qcur, qnew;
    bit apply, push_att, old_ack, drop;
    qcur     = quiet_now();
    apply    = m_pend && (qcur >= 12) && !m_taken;
    push_att = rx_ready_i && !m_taken;
    old_ack  = m_ack;
    m_ack    = push_att;
    if (push_att) m_taken = 1;
    else if (!rx_ready_i && !old_ack) m_taken = 0;
    drop = push_att && (m_q.size() == DEPTH) && !pop_i;
    if (pop_i && m_q.size() > 0) void'(m_q.pop_front());
    if (push_att && !drop) m_q.push_back(rx_data_i);
    if (m_q.size() > 0) m_data = m_q[0];
    if (drop) m_ovf = 1;
    else if (overflow_clr_i) m_ovf = 0;
    if (apply) begin
      m_div = p_div; m_pb = p_pb; m_pe = p_pe;
    end
    if (cfg_we_i) begin
      p_div = int'(cfg_divider_i); p_pb = cfg_parity_bit_i; p_pe = cfg_parity_even_i; m_pend = 1;
    end else if (apply) begin
      m_pend = 0;
    end
    if (!rx_serial_i) begin
      m_base = 0; m_hi = 0;
    end else if (apply) begin
      m_base = qcur; m_hi = 0;
    end else if (qcur < IDLE) begin
      m_hi++;
    end
    qnew    = quiet_now();
    m_to    = m_burst && (qcur != IDLE) && (qnew == IDLE);
    m_burst = push_att || (m_burst && !m_to);
  endtask

  task automatic compare_all();
    check_eq("ack",      32'(rx_ack_o),           32'(m_ack));
    check_eq("divider",  32'(rx_clock_divider_o), 32'(m_div));
    check_eq("par_bit",  32'(rx_parity_bit_o),    32'(m_pb));
    check_eq("par_even", 32'(rx_parity_even_o),   32'(m_pe));
    check_eq("pending",  32'(cfg_pending_o),      32'(m_pend));
    check_eq("count",    32'(count_o),            32'(m_q.size()));
    check_eq("valid",    32'(valid_o),            32'(m_q.size() > 0));
    check_eq("data",     32'(data_o),             32'(m_data));
    check_eq("overflow", 32'(overflow_o),         32'(m_ovf));
    check_eq("timeout",  32'(timeout_o),          32'(m_to));
  endtask

  task automatic step();
    @(posedge clock_i);
    if (!reset_n_i) model_reset();
    else model_edge();
    #1;
    compare_all();
    if (timeout_o === 1'b1) to_seen++;
  endtask

  // Receiver stand-in: a frame of line activity, then ready held until acked
  task automatic send_byte(input logic [7:0] b, input bit pop_w, input bit clr_w);
    int n;
    rx_serial_i = 1'b0;
    repeat ($urandom_range(9, 20)) step();
    rx_serial_i = 1'b1;
    step();
    rx_data_i = b; rx_ready_i = 1'b1; pop_i = pop_w; overflow_clr_i = clr_w;
    step();
    pop_i = 1'b0; overflow_clr_i = 1'b0;
    n = 0;
    while (rx_ack_o !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (n == 8) check_eq("ack_timeout", 32'(rx_ack_o), 32'd1);
    rx_ready_i = 1'b0;
    step();
  endtask

  task automatic do_cfg(input logic [DIVW-1:0] d, input bit pb, input bit pe);
    cfg_divider_i = d; cfg_parity_bit_i = pb; cfg_parity_even_i = pe; cfg_we_i = 1'b1;
    step();
    cfg_we_i = 1'b0;
  endtask

  logic [DIVW-1:0] divs [5] = '{16'd0, 16'd1, 16'd3, 16'd5, 16'd16};

  initial begin
    reset_n_i = 1'b0; rx_serial_i = 1'b1; rx_data_i = 8'h00; rx_ready_i = 1'b0;
    cfg_we_i = 1'b0; cfg_divider_i = '0; cfg_parity_bit_i = 1'b0; cfg_parity_even_i = 1'b0;
    pop_i = 1'b0; overflow_clr_i = 1'b0;
    model_reset();
    repeat (3) step();
    reset_n_i = 1'b1;
    step();

    // Single byte handshake
    send_byte(8'hA5, 0, 0);
    check_eq("t1_count", 32'(count_o), 32'd1);
    check_eq("t1_data",  32'(data_o),  32'hA5);
    pop_i = 1'b1; step(); pop_i = 1'b0;

    // Fill past depth, then overflow clear and set-wins
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 0, 0);
    send_byte(8'hEE, 0, 0);
    check_eq("fill_count", 32'(count_o),    32'd16);
    check_eq("fill_ovf",   32'(overflow_o), 32'd1);
    overflow_clr_i = 1'b1; step(); overflow_clr_i = 1'b0;
    check_eq("ovf_clr", 32'(overflow_o), 32'd0);
    send_byte(8'h77, 0, 1);
    check_eq("ovf_set_wins", 32'(overflow_o), 32'd1);
    overflow_clr_i = 1'b1; step(); overflow_clr_i = 1'b0;

    // Push and pop together while full
    send_byte(8'h99, 1, 0);
    check_eq("full_pp_count", 32'(count_o),    32'd16);
    check_eq("full_pp_ovf",   32'(overflow_o), 32'd0);
    pop_i = 1'b1; repeat (DEPTH + 1) step(); pop_i = 1'b0;
    check_eq("drain_valid", 32'(valid_o), 32'd0);

    // Deferred configuration while the line is busy
    rx_serial_i = 1'b0; repeat (3) step();
    do_cfg(16'h0010, 1, 1);
    check_eq("cfg_pend", 32'(cfg_pending_o),      32'd1);
    check_eq("cfg_hold", 32'(rx_clock_divider_o), 32'(DEF_DIV));
    rx_serial_i = 1'b1;
    repeat (12 * DEF_DIV) step();
    check_eq("cfg_not_early", 32'(cfg_pending_o), 32'd1);
    step();
    check_eq("cfg_applied", 32'(rx_clock_divider_o), 32'h10);
    check_eq("cfg_cleared", 32'(cfg_pending_o),      32'd0);

    // Burst then idle timeout, and no repeat pulse
    to_seen = 0;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, 0);
    repeat (IDLE * 16 + 40) step();
    check_eq("timeout_once", 32'(to_seen), 32'd1);
    to_seen = 0;
    repeat (600) step();
    check_eq("timeout_norepeat", 32'(to_seen), 32'd0);

    // Randomized mix of traffic, pops, config writes and quiet periods
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0, 1: send_byte(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
        2: begin
          repeat ($urandom_range(1, 8)) begin
            pop_i = 1'($urandom); overflow_clr_i = ($urandom_range(0, 3) == 0);
            step();
          end
          pop_i = 1'b0; overflow_clr_i = 1'b0;
        end
        3: do_cfg(divs[$urandom_range(0, 4)], 1'($urandom), 1'($urandom));
        default: begin
          rx_serial_i = 1'b1;
          repeat ($urandom_range(50, 700)) step();
        end
      endcase
    end

    // Asynchronous reset in the middle of an ack
    rx_serial_i = 1'b0; repeat (10) step(); rx_serial_i = 1'b1;
    rx_data_i = 8'h3C; rx_ready_i = 1'b1;
    step();
    check_eq("rst_pre_ack", 32'(rx_ack_o), 32'd1);
    #2 reset_n_i = 1'b0;
    #1;
    check_eq("rst_ack",   32'(rx_ack_o),           32'd0);
    check_eq("rst_count", 32'(count_o),            32'd0);
    check_eq("rst_valid", 32'(valid_o),            32'd0);
    check_eq("rst_div",   32'(rx_clock_divider_o), 32'(DEF_DIV));
    rx_ready_i = 1'b0;
    model_reset();
    repeat (2) step();
    reset_n_i = 1'b1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller that sits between the UART receiver and the CPU bus.
- Owns the receiver's configuration: it drives the clock divider and parity mode, and applies CPU-requested changes only when the serial line is quiet.
- Drains received bytes through the receiver's ready/ack handshake into a local FIFO and flags overflow.
- Raises a one-shot idle-timeout pulse after a burst of bytes ends, so firmware can detect packet boundaries.

Parameters:
- CLOCK_DIVIDER_WIDTH, 16: width of the divider bus shared with the receiver.
- DEFAULT_DIVIDER, 87: divider value driven out of reset.
- FIFO_DEPTH, 16: receive FIFO entries; must be a power of 2 and ≥2.
- IDLE_BITS, 32: quiet bit-times after the last byte before timeout_o fires; must be ≥12.

Ports:
- clock_i  in  1  system clock
- reset_n_i  in  1  asynchronous, active-low reset
- rx_serial_i  in  1  same serial line the receiver samples (already synchronised)
- rx_data_i  in  8  receiver data bus
- rx_ready_i  in  1  receiver byte-ready flag
- rx_ack_o  out  1  acknowledge to receiver
- rx_clock_divider_o  out  CLOCK_DIVIDER_WIDTH  active divider
- rx_parity_bit_o  out  1  active parity enable
- rx_parity_even_o  out  1  active parity polarity
- cfg_we_i  in  1  one-cycle write of pending configuration
- cfg_divider_i  in  CLOCK_DIVIDER_WIDTH  requested divider
- cfg_parity_bit_i  in  1  requested parity enable
- cfg_parity_even_i  in  1  requested parity polarity
- cfg_pending_o  out  1  a written configuration is not yet applied
- pop_i  in  1  consume FIFO head
- data_o  out  8  FIFO head (valid when valid_o=1)
- valid_o  out  1  FIFO non-empty
- count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow_o  out  1  sticky: a byte was dropped
- overflow_clr_i  in  1  clears overflow_o
- timeout_o  out  1  one-cycle idle-timeout pulse

Behaviour:
- Reset (async, active-low): rx_ack_o=0, divider=DEFAULT_DIVIDER, parity_bit=0, parity_even=0, cfg_pending_o=0, FIFO empty (valid_o=0, count_o=0, data_o=0), overflow_o=0, timeout_o=0, ack FSM in A_IDLE, quiet counter saturated (line treated as quiet), burst flag=0.
- Ack FSM states: A_IDLE, A_ACK, A_WAIT.
  - A_IDLE with rx_ready_i=1: push rx_data_i, or drop it and set overflow_o if the FIFO is full and pop_i=0. Set rx_ack_o<=1 and go to A_ACK.
  - A_ACK: rx_ack_o<=0, go to A_WAIT. The ack is exactly one cycle high, then low, which re-arms the receiver's ack edge detector.
  - A_WAIT: stay until rx_ready_i=0, then go to A_IDLE. Each frame is pushed at most once.
- FIFO:
  - Push-to-valid_o latency is 1 cycle.
  - Push and pop in the same cycle while full: both succeed and count is unchanged.
  - Pop while empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - data_o is registered and holds its last value when empty.
- overflow_o: set on a dropped byte and cleared by overflow_clr_i. Set wins if both occur in the same cycle.
- Quiet timer:
  - A bit timer counts rx_clock_divider_o cycles while rx_serial_i=1. Any low sample clears the timer and the quiet-bit counter.
  - The quiet-bit counter saturates at IDLE_BITS.
  - line_quiet means the quiet-bit counter is ≥12.
- Timeout:
  - The burst flag is set on every push attempt, including dropped bytes.
  - When the quiet counter first reaches IDLE_BITS with burst=1, pulse timeout_o for 1 cycle and clear burst.
  - No repeat pulse until another byte arrives.
- Config:
  - cfg_we_i latches the requested values into a pending register and sets cfg_pending_o. A later write overwrites the pending values.
  - Pending values are applied to the rx_* outputs on the first cycle with cfg_pending_o=1, line_quiet=1 and the ack FSM in A_IDLE. cfg_pending_o clears in that same cycle.
  - cfg_we_i in the apply cycle: the new values become pending and cfg_pending_o stays 1.
  - Applying resets the bit timer but not the quiet counter.
- Divider values <2 are passed through unchanged. The receiver ignores frames at such values, and the quiet bit timer treats a bit-time as 2 cycles.
- All arithmetic is unsigned. Counters never wrap; they saturate.

Decomposition:
- uart_pkg holds:
  - ack FSM state encoding (A_IDLE, A_ACK, A_WAIT);
  - QUIET_FRAME_BITS=12;
  - a divider-floor constant of 2.
- One sub-module: uart_rx_fifo (parameterised depth/width, push/pop, count, full/empty).

Test Plan:
- Receiver model presents 0xA5 (ready high until acked): FIFO gets exactly one entry, rx_ack_o high for exactly 1 cycle, and data_o=0xA5, valid_o=1 one cycle after the push.
- 17 bytes with no pop at FIFO_DEPTH=16: count_o=16, overflow_o=1, the 17th byte is lost. overflow_clr_i clears overflow_o; a simultaneous drop keeps it set.
- Full FIFO with push and pop in the same cycle: count stays 16, the head advances, overflow_o stays 0.
- cfg_we_i (divider 0x0010, parity even) mid-frame with serial low: cfg_pending_o=1 and outputs unchanged. After 12 high bit-times at the old divider: outputs update and cfg_pending_o=0.
- Burst of 3 bytes, then line high: timeout_o pulses exactly once, IDLE_BITS bit-times after the last serial low. No pulse after a further quiet period with no bytes.
- reset_n_i asserted mid-ack in A_ACK: rx_ack_o=0, FIFO empty and divider=DEFAULT_DIVIDER immediately, without waiting for a clock edge.
